// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I main controller: FSM states,
// opcodes, datapath select codes and the bundled control word.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Everything the FSM drives except pcWrite, which folds in zero.
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    // Control word seen in FETCH; also the value held while in reset.
    function automatic ctrl_t fetch_ctrl();
        ctrl_t c;
        c            = '0;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
        return c;
    endfunction

endpackage

// File: rtl/mc_main_ctrl_imm_src_dec.sv
// Immediate-type decoder: maps the opcode to the immediate format select.
module imm_src_dec
    import mc_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle RV32I datapath.
// Optional memory wait states are enabled with `MC_MEM_WAIT_EN (adds mem_ready).
module mc_main_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
`ifdef MC_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluop,
    output logic [1:0] immSrc,
    output logic       illegal
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;
    logic   mem_ready_w;

`ifdef MC_MEM_WAIT_EN
    assign mem_ready_w = mem_ready;
`else
    assign mem_ready_w = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            S_FETCH: begin
                ctrl           = fetch_ctrl();
                ctrl.ir_write  = mem_ready_w;
                ctrl.pc_update = mem_ready_w;
                if (mem_ready_w) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target oldPC+imm is precomputed here into ALUOut.
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d      = S_FETCH;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
                if (mem_ready_w) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ctrl.result_src = RES_READDATA;
                ctrl.reg_write  = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = mem_ready_w;
                if (mem_ready_w) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = S_ALUWB;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = S_ALUWB;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while oldPC+4 becomes the link value.
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_update = 1'b1;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                state_d         = S_FETCH;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
                state_d         = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset wins over any state: no writes, FETCH selects on the datapath.
        if (reset) begin
            state_d = S_FETCH;
            ctrl    = fetch_ctrl();
        end
    end

    assign pcWrite   = ctrl.pc_update | (ctrl.branch & zero);
    assign adrSrc    = ctrl.adr_src;
    assign memWrite  = ctrl.mem_write;
    assign irWrite   = ctrl.ir_write;
    assign regWrite  = ctrl.reg_write;
    assign resultSrc = ctrl.result_src;
    assign aluSrcA   = ctrl.alu_src_a;
    assign aluSrcB   = ctrl.alu_src_b;
    assign aluop     = ctrl.alu_op;
    assign illegal   = ctrl.illegal;

    imm_src_dec u_imm_src_dec (
        .op      (op),
        .imm_src (immSrc)
    );

endmodule
